exec_sequencer: RTL and testbench

Execute stage of the 8-bit accumulator CPU. Sits directly downstream of the fetch/decode sequencer (PC/AR/IR, indirect resolution) and upstream of the 16x8 memory.
- Accepts one decoded instruction at a time via valid/ready.
- Sequences operand read, ALU operation, store and branch/halt.
- Owns AC and the E (carry) flag.

---
 rtl/exec_sequencer.sv | 163 ++++++++++++++++
 tb/tb_exec_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Execute stage of the 8-bit accumulator CPU: operand read, ALU, store, branch/halt.
// Optional retired-instruction counter is built only when RETIRE_CNT_EN is defined.
module exec_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [2:0]        dec_opcode,
  input  logic              dec_i,
  input  logic [ADDR_W-1:0] dec_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_value,
  output logic [DATA_W-1:0] ac,
  output logic              e_flag,
  output logic              z_flag,
  output logic              halted,
  output logic              busy,
  output logic [15:0]       retire_cnt
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_CMA = 3'b110;
  localparam logic [2:0] OP_BUN = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_WR, S_BR, S_HALT} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          opcode_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   ac_reg, ac_next;
  logic                e_reg, e_next;
  logic                accept;
  logic [DATA_W:0]     add_sum, sub_sum, shl_sum;

  assign accept = (state_reg == S_IDLE) && dec_valid;

  // State register plus AC/E and the latched instruction fields.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      ac_reg     <= '0;
      e_reg      <= 1'b0;
      opcode_reg <= '0;
      addr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ac_reg    <= ac_next;
      e_reg     <= e_next;
      if (accept) begin
        opcode_reg <= dec_opcode;
        addr_reg   <= dec_addr;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (dec_valid) begin
          case (dec_opcode)
            OP_ADD, OP_SUB, OP_XOR, OP_LDA: state_next = S_RD;
            OP_SHL, OP_CMA:                 state_next = S_EX;
            OP_STA:                         state_next = S_WR;
            OP_BUN:                         state_next = dec_i ? S_HALT : S_BR;
            default:                        state_next = S_IDLE;
          endcase
        end
      end
      S_RD:    state_next = S_EX;
      S_EX:    state_next = S_IDLE;
      S_WR:    state_next = S_IDLE;
      S_BR:    state_next = S_IDLE;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // SUB is AC + ~DR + 1, so the carry out means "no borrow".
  assign add_sum = {1'b0, ac_reg} + {1'b0, mem_rdata};
  assign sub_sum = {1'b0, ac_reg} + {1'b0, ~mem_rdata} + {{DATA_W{1'b0}}, 1'b1};
  assign shl_sum = {1'b0, ac_reg} + {1'b0, ac_reg};

  always_comb begin
    ac_next = ac_reg;
    e_next  = e_reg;
    if (state_reg == S_EX) begin
      case (opcode_reg)
        OP_ADD:  {e_next, ac_next} = add_sum;
        OP_SUB:  {e_next, ac_next} = sub_sum;
        OP_XOR:  ac_next = ac_reg ^ mem_rdata;
        OP_SHL:  {e_next, ac_next} = shl_sum;
        OP_LDA:  ac_next = mem_rdata;
        OP_CMA:  ac_next = ~ac_reg;
        default: ac_next = ac_reg;
      endcase
    end
  end

  // Output logic; strobes are gated by RST so a reset cycle never writes or branches.
  always_comb begin
    dec_ready = 1'b0;
    mem_write = 1'b0;
    pc_load   = 1'b0;
    halted    = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      S_IDLE: begin
        dec_ready = !RST;
        busy      = 1'b0;
      end
      S_WR:   mem_write = !RST;
      S_BR:   pc_load   = !RST;
      S_HALT: begin
        halted = 1'b1;
        busy   = 1'b0;
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = ac_reg;
  assign pc_value  = addr_reg;
  assign ac        = ac_reg;
  assign e_flag    = e_reg;
  assign z_flag    = (ac_reg == '0);

`ifdef RETIRE_CNT_EN
  logic        retire_evt;
  logic [15:0] retire_cnt_reg;

  assign retire_evt = ((state_next == S_IDLE) &&
                       ((state_reg == S_EX) || (state_reg == S_WR) || (state_reg == S_BR))) ||
                      ((state_reg == S_IDLE) && (state_next == S_HALT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      retire_cnt_reg <= '0;
    end else if (retire_evt && (retire_cnt_reg != 16'hFFFF)) begin
      retire_cnt_reg <= retire_cnt_reg + 16'd1;
    end
  end

  assign retire_cnt = retire_cnt_reg;
`else
  assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer with a small registered-read memory model.
module tb_exec_sequencer;

  logic       CLK;
  logic       RST;
  logic       dec_valid;
  logic       dec_ready;
  logic [2:0] dec_opcode;
  logic       dec_i;
  logic [3:0] dec_addr;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_write;
  logic [7:0] mem_rdata;
  logic       pc_load;
  logic [3:0] pc_value;
  logic [7:0] ac;
  logic       e_flag;
  logic       z_flag;
  logic       halted;
  logic       busy;
  logic [15:0] retire_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [16];

  int         busy_cycles;
  int         wr_cnt;
  int         pcl_cnt;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] pcv;

  exec_sequencer dut (
    .CLK(CLK), .RST(RST),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_i(dec_i), .dec_addr(dec_addr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .pc_load(pc_load), .pc_value(pc_value),
    .ac(ac), .e_flag(e_flag), .z_flag(z_flag),
    .halted(halted), .busy(busy), .retire_cnt(retire_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory: write on strobe, DR valid the cycle after the address is presented.
  always @(posedge CLK) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Issue one instruction and follow it until the stage is ready again (or halts).
  task automatic run_instr(input logic [2:0] op, input logic i, input logic [3:0] a);
    @(negedge CLK);
    chk("ready_before_issue", dec_ready, 1);
    dec_opcode = op; dec_i = i; dec_addr = a; dec_valid = 1'b1;
    @(posedge CLK); #1;
    dec_valid = 1'b0;
    busy_cycles = 0; wr_cnt = 0; pcl_cnt = 0;
    while (!dec_ready && !halted && busy_cycles < 20) begin
      if (mem_write) begin wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (pc_load) begin pcl_cnt++; pcv = pc_value; end
      @(posedge CLK); #1;
      busy_cycles++;
    end
    if (busy_cycles >= 20) chk("timeout", busy_cycles, 0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
    mem[5] = 8'h3C; mem[2] = 8'h20; mem[3] = 8'h20; mem[4] = 8'h11;
    mem[6] = 8'hF0; mem[8] = 8'hA5; mem[10] = 8'h66;
    RST = 1'b1; dec_valid = 1'b0; dec_opcode = 3'b000; dec_i = 1'b0; dec_addr = 4'h0;

    // 1. reset
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      chk("rst_mem_write", mem_write, 0);
      chk("rst_dec_ready", dec_ready, 0);
    end
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_ac", ac, 8'h00);
    chk("rst_e", e_flag, 0);
    chk("rst_z", z_flag, 1);
    chk("rst_halted", halted, 0);
    chk("rst_ready", dec_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_retire", retire_cnt, 0);

    // 2. LDA 5
    run_instr(3'b100, 1'b0, 4'd5);
    chk("lda_latency", busy_cycles, 2);
    chk("lda_ac", ac, 8'h3C);
    chk("lda_e", e_flag, 0);
    chk("lda_z", z_flag, 0);

    // 3. arithmetic
    run_instr(3'b100, 1'b0, 4'd6);
    chk("lda_f0", ac, 8'hF0);
    run_instr(3'b000, 1'b0, 4'd2);
    chk("add_ac", ac, 8'h10);
    chk("add_e", e_flag, 1);
    run_instr(3'b001, 1'b0, 4'd3);
    chk("sub_ac", ac, 8'hF0);
    chk("sub_e", e_flag, 0);
    run_instr(3'b011, 1'b0, 4'd0);
    chk("shl_latency", busy_cycles, 1);
    chk("shl_ac", ac, 8'hE0);
    chk("shl_e", e_flag, 1);
    run_instr(3'b110, 1'b0, 4'd0);
    chk("cma_ac", ac, 8'h1F);
    chk("cma_e", e_flag, 1);
    run_instr(3'b010, 1'b0, 4'd5);
    chk("xor_ac", ac, 8'h23);
    chk("xor_e", e_flag, 1);

    // 4. STA then reload
    run_instr(3'b100, 1'b0, 4'd8);
    chk("lda_a5_e_kept", e_flag, 1);
    run_instr(3'b101, 1'b0, 4'd9);
    chk("sta_latency", busy_cycles, 1);
    chk("sta_wr_cnt", wr_cnt, 1);
    chk("sta_addr", wr_addr, 4'd9);
    chk("sta_data", wr_data, 8'hA5);
    run_instr(3'b100, 1'b0, 4'd5);
    run_instr(3'b100, 1'b0, 4'd9);
    chk("reload_ac", ac, 8'hA5);

    // 5. BUN and HLT
    run_instr(3'b111, 1'b0, 4'd7);
    chk("bun_pcl_cnt", pcl_cnt, 1);
    chk("bun_pcv", pcv, 4'd7);
    chk("bun_pc_load_after", pc_load, 0);
    run_instr(3'b111, 1'b1, 4'd0);
    chk("hlt_halted", halted, 1);
    chk("hlt_ready", dec_ready, 0);
    chk("hlt_busy", busy, 0);
    @(negedge CLK);
    dec_opcode = 3'b100; dec_i = 1'b0; dec_addr = 4'd5; dec_valid = 1'b1;
    repeat (3) @(posedge CLK);
    #1; dec_valid = 1'b0;
    chk("hlt_ignore_ac", ac, 8'hA5);
    chk("hlt_still", halted, 1);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    chk("hlt_rst_halted", halted, 0);
    chk("hlt_rst_ready", dec_ready, 1);

    // 6. RST during the WR cycle of STA 4
    run_instr(3'b100, 1'b0, 4'd10);
    chk("lda_66", ac, 8'h66);
    @(negedge CLK);
    dec_opcode = 3'b101; dec_i = 1'b0; dec_addr = 4'd4; dec_valid = 1'b1;
    @(posedge CLK); #1;
    dec_valid = 1'b0;
    chk("wr_state_busy", busy, 1);
    RST = 1'b1; #1;
    chk("wr_rst_no_write", mem_write, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("wr_rst_mem4", mem[4], 8'h11);
    chk("wr_rst_idle", busy, 0);
    chk("wr_rst_ac", ac, 8'h00);
    @(posedge CLK); #1;
    chk("wr_rst_ready", dec_ready, 1);

    // five retirements after reset
    run_instr(3'b100, 1'b0, 4'd4);
    chk("r1_ac", ac, 8'h11);
    run_instr(3'b000, 1'b0, 4'd2);
    chk("r2_ac", ac, 8'h31);
    chk("r2_e", e_flag, 0);
    run_instr(3'b011, 1'b0, 4'd0);
    chk("r3_ac", ac, 8'h62);
    run_instr(3'b101, 1'b0, 4'd12);
    run_instr(3'b111, 1'b0, 4'd3);
    chk("r5_mem12", mem[12], 8'h62);
`ifdef RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, 16'd5);
`else
    chk("retire_cnt", retire_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
